// File: rtl/usb_dpo_pktzr.sv
`default_nettype none
// ============================================================================
// Module   : usb_dpo_pktzr
// Purpose  : Upstream framing stage for one DP2/DP3 output FIFO port of
//            usb_if_wrpr. Wraps a raw 32-bit word stream into packets of
//            header {HDR_TAG, pkt_id}, payload words, and trailer
//            {xor-checksum, payload word count}.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i             clock (same as usb_if_wrpr clk_dpN_wr_i)
//   rst_i             asynchronous active-high reset
//   en_i              packetizer enable, sampled only in IDLE
//   dt_i / vld_i      source word and its valid
//   last_i            marks dt_i as the final payload word of the packet
//   rdy_o             source word accepted when vld_i & rdy_o
//   dpo_dti_o         registered word to the FIFO
//   dpo_wr_o          registered one-cycle FIFO write strobe
//   dpo_full_i        FIFO full
//   dpo_almst_full_i  FIFO almost full (blocks payload only)
//   pkt_cnt_o         completed-packet count, wraps modulo 2^16
//   busy_o            high whenever not IDLE
// ============================================================================
module usb_dpo_pktzr #(
  parameter int unsigned MAX_LEN  = 256,
  parameter logic [15:0] HDR_TAG  = 16'hA5A5,
  parameter int unsigned FLUSH_TO = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [31:0] dt_i,
  input  logic        vld_i,
  input  logic        last_i,
  output logic        rdy_o,
  output logic [31:0] dpo_dti_o,
  output logic        dpo_wr_o,
  input  logic        dpo_full_i,
  input  logic        dpo_almst_full_i,
  output logic [15:0] pkt_cnt_o,
  output logic        busy_o
);

  localparam int unsigned      TMR_W     = $clog2(FLUSH_TO + 1);
  localparam logic [16:0]      c_max_len = 17'(MAX_LEN);
  // The timer value in the cycle before it would reach FLUSH_TO-1; moving
  // to TRL here puts the trailer write exactly FLUSH_TO cycles after the
  // last payload write.
  localparam logic [TMR_W-1:0] c_tmr_lim = TMR_W'(FLUSH_TO - 2);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_TRL     = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [15:0]      r_cnt;
  logic [15:0]      w_cnt_nxt;
  logic [15:0]      r_cs;
  logic [15:0]      w_cs_nxt;
  logic [TMR_W-1:0] r_tmr;
  logic [TMR_W-1:0] w_tmr_nxt;
  logic [15:0]      r_pkt_id;
  logic [15:0]      w_pkt_id_nxt;
  logic [31:0]      r_dti;
  logic [31:0]      w_dti_nxt;
  logic             r_wr;
  logic             w_wr_nxt;
  logic             w_rdy;
  logic             w_acc;
  logic [16:0]      w_cnt_inc;

  assign w_rdy     = (r_state == ST_PAYLOAD) & ~dpo_full_i & ~dpo_almst_full_i;
  assign w_acc     = vld_i & w_rdy;
  assign w_cnt_inc = {1'b0, r_cnt} + 17'd1;

  assign rdy_o     = w_rdy;
  assign dpo_dti_o = r_dti;
  assign dpo_wr_o  = r_wr;
  // pkt_id and the completed-packet count always advance together.
  assign pkt_cnt_o = r_pkt_id;
  assign busy_o    = (r_state != ST_IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_cs     <= '0;
      r_tmr    <= '0;
      r_pkt_id <= '0;
      r_dti    <= '0;
      r_wr     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_cs     <= w_cs_nxt;
      r_tmr    <= w_tmr_nxt;
      r_pkt_id <= w_pkt_id_nxt;
      r_dti    <= w_dti_nxt;
      r_wr     <= w_wr_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_cs_nxt     = r_cs;
    w_tmr_nxt    = r_tmr;
    w_pkt_id_nxt = r_pkt_id;
    w_dti_nxt    = r_dti;
    w_wr_nxt     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // The pending source word only triggers the header; it is
        // consumed later in PAYLOAD.
        if (en_i && vld_i && !dpo_full_i) begin
          w_wr_nxt    = 1'b1;
          w_dti_nxt   = {HDR_TAG, r_pkt_id};
          w_state_nxt = ST_PAYLOAD;
        end
      end

      ST_PAYLOAD: begin
        if (w_acc) begin
          w_wr_nxt  = 1'b1;
          w_dti_nxt = dt_i;
          w_cnt_nxt = w_cnt_inc[15:0];
          w_cs_nxt  = r_cs ^ dt_i[31:16] ^ dt_i[15:0];
          w_tmr_nxt = '0;
          if (last_i || (w_cnt_inc == c_max_len)) begin
            w_state_nxt = ST_TRL;
          end
        end else if (r_cnt != 16'd0) begin
          // Flush timer only runs once the packet holds at least one word,
          // so an empty packet is never closed.
          w_tmr_nxt = r_tmr + TMR_W'(1);
          if (r_tmr == c_tmr_lim) begin
            w_state_nxt = ST_TRL;
          end
        end
      end

      ST_TRL: begin
        if (!dpo_full_i) begin
          w_wr_nxt     = 1'b1;
          w_dti_nxt    = {r_cs, r_cnt};
          w_pkt_id_nxt = r_pkt_id + 16'd1;
          w_cnt_nxt    = '0;
          w_cs_nxt     = '0;
          w_tmr_nxt    = '0;
          w_state_nxt  = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_usb_dpo_pktzr.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_dpo_pktzr
// Purpose  : Self-checking bench for usb_dpo_pktzr (MAX_LEN=4, FLUSH_TO=16).
//            FIFO writes are captured by a monitor and compared against
//            packet streams built from the framing rules.
// Revision : 1.0  initial release
// ============================================================================
module tb_usb_dpo_pktzr;

  localparam int MAXL = 4;
  localparam int FTO  = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        vld = 1'b0;
  logic        last = 1'b0;
  logic        full = 1'b0;
  logic        afull = 1'b0;
  logic [31:0] dt = '0;
  logic        rdy;
  logic [31:0] dti;
  logic        wr;
  logic [15:0] pktcnt;
  logic        busy;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [31:0] mon_q[$];
  int          mon_t[$];
  logic        prev_full = 1'b0;
  bit          rand_flags = 1'b0;
  int          blk_run = 0;

  usb_dpo_pktzr #(
    .MAX_LEN (MAXL),
    .HDR_TAG (16'hA5A5),
    .FLUSH_TO(FTO)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .en_i            (en),
    .dt_i            (dt),
    .vld_i           (vld),
    .last_i          (last),
    .rdy_o           (rdy),
    .dpo_dti_o       (dti),
    .dpo_wr_o        (wr),
    .dpo_full_i      (full),
    .dpo_almst_full_i(afull),
    .pkt_cnt_o       (pktcnt),
    .busy_o          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO-side monitor plus flag-protocol checks.
  always @(negedge clk) begin
    if (wr === 1'b1) begin
      mon_q.push_back(dti);
      mon_t.push_back(cyc);
      n_cmp++;
      if (prev_full !== 1'b0) begin
        n_err++;
        $display("FAIL wr_while_full: wrote %h while full was %b on deciding cycle (required 0)", dti, prev_full);
      end
    end
    if (full || afull) begin
      n_cmp++;
      if (rdy !== 1'b0) begin
        n_err++;
        $display("FAIL rdy_flags: rdy_o=%b with full=%b afull=%b (required 0)", rdy, full, afull);
      end
    end
    prev_full = full;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (required completion)");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_flags) begin
      if (blk_run >= 4) begin
        full = 1'b0; afull = 1'b0; blk_run = 0;
      end else begin
        full  = ($urandom_range(0, 7) == 0);
        afull = ($urandom_range(0, 3) == 0);
        blk_run = (full || afull) ? blk_run + 1 : 0;
      end
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; vld = 1'b0; last = 1'b0; full = 1'b0; afull = 1'b0;
    rand_flags = 1'b0; blk_run = 0;
    repeat (2) step();
    rst = 1'b0;
    step();
  endtask

  task automatic send_word(input logic [31:0] d, input logic l, input int gap);
    bit acc;
    acc = 1'b0;
    if (gap > 0) begin
      vld = 1'b0; last = 1'b0;
      for (int i = 0; i < gap; i++) step();
    end
    vld = 1'b1; dt = d; last = l;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = rdy;
      step();
    end
    vld = 1'b0; last = 1'b0;
    if (!acc) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: word %h not accepted in 200 cycles (required accept)", d);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (!busy) break;
      step();
    end
    if (busy) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: busy_o=%b after 300 cycles (required 0)", busy);
    end
    step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    n_cmp++;
    if ({wr, dti, pktcnt, busy, rdy} !== 51'd0) begin
      n_err++;
      $display("FAIL reset_outputs: wr=%b dti=%h pkt=%h busy=%b rdy=%b (required all 0)", wr, dti, pktcnt, busy, rdy);
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: busy_o=%b (required 0)", busy);
    end
  endtask

  task automatic test_stream_maxlen();
    logic [31:0] e[12];
    e = '{32'hA5A50000, 32'd0, 32'd1, 32'd2, 32'd3, 32'h00000004,
          32'hA5A50001, 32'd4, 32'd5, 32'd6, 32'd7, 32'h00000004};
    apply_reset(); en = 1'b1; mon_q.delete();
    for (int k = 0; k < 8; k++) send_word(32'(k), 1'b0, 0);
    drain();
    n_cmp++;
    if (mon_q.size() != 12) begin
      n_err++;
      $display("FAIL maxlen_len: %0d writes (required 12)", mon_q.size());
    end
    for (int i = 0; i < 12 && i < mon_q.size(); i++) begin
      n_cmp++;
      if (mon_q[i] !== e[i]) begin
        n_err++;
        $display("FAIL maxlen_word[%0d]: got %h (required %h)", i, mon_q[i], e[i]);
        break;
      end
    end
    n_cmp++;
    if (pktcnt !== 16'd2 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL maxlen_end: pkt_cnt=%0d busy=%b (required 2, 0)", pktcnt, busy);
    end
  endtask

  task automatic test_checksum();
    logic [31:0] e[4];
    e = '{32'hA5A50000, 32'h00010002, 32'h00030004, 32'h00040002};
    apply_reset(); en = 1'b1; mon_q.delete();
    send_word(32'h00010002, 1'b0, 0);
    send_word(32'h00030004, 1'b1, 0);
    drain();
    n_cmp++;
    if (mon_q.size() != 4) begin
      n_err++;
      $display("FAIL cs_len: %0d writes (required 4)", mon_q.size());
    end
    for (int i = 0; i < 4 && i < mon_q.size(); i++) begin
      n_cmp++;
      if (mon_q[i] !== e[i]) begin
        n_err++;
        $display("FAIL cs_word[%0d]: got %h (required %h)", i, mon_q[i], e[i]);
        break;
      end
    end
    n_cmp++;
    if (pktcnt !== 16'd1) begin
      n_err++;
      $display("FAIL cs_pktcnt: %0d (required 1)", pktcnt);
    end
  endtask

  task automatic test_almost_full();
    logic [31:0] e[6];
    e = '{32'hA5A50000, 32'd0, 32'd1, 32'd2, 32'd3, 32'h00000004};
    apply_reset(); en = 1'b1; mon_q.delete();
    // Header must go out even with almost-full raised.
    afull = 1'b1; vld = 1'b1; dt = 32'd0; last = 1'b0;
    for (int i = 0; i < 3; i++) step();
    n_cmp++;
    if (mon_q.size() != 1 || mon_q[0] !== 32'hA5A50000) begin
      n_err++;
      $display("FAIL afull_hdr: %0d writes first=%h (required 1, a5a50000)", mon_q.size(), (mon_q.size() > 0) ? mon_q[0] : 32'hX);
    end
    afull = 1'b0;
    send_word(32'd0, 1'b0, 0);
    send_word(32'd1, 1'b0, 0);
    vld = 1'b1; dt = 32'd2; afull = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rdy !== 1'b0) begin
        n_err++;
        $display("FAIL afull_rdy[%0d]: rdy_o=%b (required 0)", i, rdy);
      end
      if (i > 0) begin
        n_cmp++;
        if (wr !== 1'b0) begin
          n_err++;
          $display("FAIL afull_wr[%0d]: dpo_wr_o=%b data %h (required 0)", i, wr, dti);
        end
      end
      step();
    end
    afull = 1'b0;
    send_word(32'd2, 1'b0, 0);
    send_word(32'd3, 1'b0, 0);
    afull = 1'b1;  // trailer must still be written
    drain();
    afull = 1'b0;
    n_cmp++;
    if (mon_q.size() != 6) begin
      n_err++;
      $display("FAIL afull_len: %0d writes (required 6)", mon_q.size());
    end
    for (int i = 0; i < 6 && i < mon_q.size(); i++) begin
      n_cmp++;
      if (mon_q[i] !== e[i]) begin
        n_err++;
        $display("FAIL afull_word[%0d]: got %h (required %h)", i, mon_q[i], e[i]);
        break;
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] w[3];
    logic [15:0] cs;
    apply_reset(); en = 1'b1; mon_q.delete(); mon_t.delete();
    cs = '0;
    for (int k = 0; k < 3; k++) begin
      w[k] = $urandom;
      cs = cs ^ w[k][31:16] ^ w[k][15:0];
      send_word(w[k], 1'b0, 0);
    end
    drain();
    n_cmp++;
    if (mon_q.size() != 5) begin
      n_err++;
      $display("FAIL flush_len: %0d writes (required 5)", mon_q.size());
    end else begin
      n_cmp++;
      if (mon_q[4] !== {cs, 16'd3} || mon_q[3] !== w[2]) begin
        n_err++;
        $display("FAIL flush_trl: got %h after %h (required %h after %h)", mon_q[4], mon_q[3], {cs, 16'd3}, w[2]);
      end
      n_cmp++;
      if (mon_t[4] - mon_t[3] != FTO) begin
        n_err++;
        $display("FAIL flush_time: trailer %0d cycles after last payload (required %0d)", mon_t[4] - mon_t[3], FTO);
      end
    end
    n_cmp++;
    if (busy !== 1'b0 || pktcnt !== 16'd1) begin
      n_err++;
      $display("FAIL flush_end: busy=%b pkt_cnt=%0d (required 0, 1)", busy, pktcnt);
    end
  endtask

  task automatic test_full_trl();
    logic [31:0] w;
    logic [15:0] cs;
    apply_reset(); en = 1'b1; mon_q.delete();
    cs = '0;
    for (int k = 0; k < MAXL; k++) begin
      w = $urandom;
      cs = cs ^ w[31:16] ^ w[15:0];
      send_word(w, 1'b0, 0);
    end
    full = 1'b1;
    for (int i = 0; i < 5; i++) step();
    n_cmp++;
    if (mon_q.size() != 5 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL full_hold: %0d writes busy=%b (required 5, 1)", mon_q.size(), busy);
    end
    full = 1'b0;
    step();
    n_cmp++;
    if (wr !== 1'b1 || dti !== {cs, 16'd4}) begin
      n_err++;
      $display("FAIL full_release: wr=%b dti=%h (required 1, %h)", wr, dti, {cs, 16'd4});
    end
    step();
    n_cmp++;
    if (busy !== 1'b0 || pktcnt !== 16'd1) begin
      n_err++;
      $display("FAIL full_end: busy=%b pkt_cnt=%0d (required 0, 1)", busy, pktcnt);
    end
  endtask

  task automatic test_enable();
    apply_reset(); en = 1'b0; mon_q.delete();
    vld = 1'b1; dt = 32'h5;
    for (int i = 0; i < 5; i++) step();
    n_cmp++;
    if (mon_q.size() != 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL en_off: %0d writes busy=%b (required 0, 0)", mon_q.size(), busy);
    end
    en = 1'b1;
    send_word(32'h5, 1'b0, 0);
    en = 1'b0;  // must not disturb the packet in progress
    send_word(32'h6, 1'b1, 1);
    drain();
    n_cmp++;
    if (mon_q.size() != 4 || mon_q[3] !== 32'h00030002) begin
      n_err++;
      $display("FAIL en_mid: %0d writes last=%h (required 4, 00030002)", mon_q.size(), (mon_q.size() > 0) ? mon_q[mon_q.size()-1] : 32'hX);
    end
  endtask

  task automatic test_async_reset();
    apply_reset(); en = 1'b1;
    for (int k = 0; k < MAXL; k++) send_word(32'(k), 1'b0, 0);
    drain();
    send_word(32'h11, 1'b0, 0);
    send_word(32'h22, 1'b0, 0);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({wr, dti, pktcnt, busy, rdy} !== 51'd0) begin
      n_err++;
      $display("FAIL async_rst: wr=%b dti=%h pkt=%h busy=%b rdy=%b (required all 0)", wr, dti, pktcnt, busy, rdy);
    end
    step();
    rst = 1'b0;
    mon_q.delete();
    send_word(32'h33, 1'b0, 0);
    step();
    n_cmp++;
    if (mon_q.size() < 1 || mon_q[0] !== 32'hA5A50000 || pktcnt !== 16'd0) begin
      n_err++;
      $display("FAIL async_after: first=%h pkt_cnt=%0d (required a5a50000, 0)", (mon_q.size() > 0) ? mon_q[0] : 32'hX, pktcnt);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_q[$];
    logic [31:0] w;
    logic [15:0] cs;
    bit          l;
    int          len;
    int          pid;
    apply_reset(); en = 1'b1; mon_q.delete();
    rand_flags = 1'b1;
    len = 0; cs = '0; pid = 0;
    for (int k = 0; k < 60; k++) begin
      w = $urandom;
      l = (k == 59) || ($urandom_range(0, 4) == 0);
      if (len == 0) exp_q.push_back({16'hA5A5, 16'(pid)});
      exp_q.push_back(w);
      len++;
      cs = cs ^ w[31:16] ^ w[15:0];
      if (l || len == MAXL) begin
        exp_q.push_back({cs, 16'(len)});
        pid++; len = 0; cs = '0;
      end
      send_word(w, l, $urandom_range(0, 3));
    end
    rand_flags = 1'b0; full = 1'b0; afull = 1'b0;
    drain();
    n_cmp++;
    if (mon_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL rand_len: %0d writes (required %0d)", mon_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      n_cmp++;
      if (mon_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL rand_word[%0d]: got %h (required %h)", i, mon_q[i], exp_q[i]);
        break;
      end
    end
    n_cmp++;
    if (pktcnt !== 16'(pid)) begin
      n_err++;
      $display("FAIL rand_pktcnt: %0d (required %0d)", pktcnt, pid);
    end
  endtask

  initial begin
    test_reset();
    test_stream_maxlen();
    test_checksum();
    test_almost_full();
    test_flush();
    test_full_trl();
    test_enable();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
